instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 20 ++
 rtl/instr_sequencer_byte_serializer.sv | 45 ++++
 rtl/instr_sequencer.sv | 111 +++++++++++
 tb/tb_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the decoder it feeds.
// Holds the sequencer state encoding, word geometry and the opcode constants.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        EXEC    = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    // Opcodes the decoder acts on; an all-zero word matches none of them.
    localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;

endpackage

// File: rtl/instr_sequencer_byte_serializer.sv
// Loads a 32-bit result and hands it out one byte at a time, LSB first,
// over a valid/ready interface; done pulses on acceptance of the last byte.
module byte_serializer
    import instr_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done
);

    logic [31:0] shift_reg;
    logic [1:0]  drain_idx;
    logic        active;
    logic        accept;

    assign accept    = active && out_ready;
    assign out_byte  = shift_reg[7:0];
    assign out_valid = active;
    assign done      = accept && (drain_idx == 2'(BYTES_PER_WORD - 1));

    // The register only shifts on a handshake, so a stalled consumer sees a stable byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= 32'h0;
            drain_idx <= 2'd0;
            active    <= 1'b0;
        end else if (load) begin
            shift_reg <= load_data;
            drain_idx <= 2'd0;
            active    <= 1'b1;
        end else if (accept) begin
            shift_reg <= {8'h00, shift_reg[31:8]};
            drain_idx <= drain_idx + 2'd1;
            if (drain_idx == 2'(BYTES_PER_WORD - 1)) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Assembles instruction words from a byte stream, issues them to the decoder,
// waits a fixed execution time, then streams the destination register back out.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int EXEC_CYCLES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    input  logic [31:0]          result_data,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] instr_count
);

    seq_state_t           state;
    seq_state_t           state_next;
    logic [1:0]           byte_cnt;
    logic [31:0]          assembly;
    logic [3:0]           exec_cnt;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 accept_in;
    logic                 ser_load;
    logic                 ser_valid;
    logic                 ser_done;

    // Reset gates every strobe combinationally so nothing escapes during a synchronous reset.
    assign accept_in   = in_valid && in_ready;
    assign in_ready    = (state == COLLECT) && !reset;
    assign instr_valid = (state == ISSUE) && !reset;
    assign instr       = instr_valid ? assembly : NOP_WORD;
    assign busy        = (state != COLLECT) && !reset;
    assign out_valid   = ser_valid && !reset;
    assign instr_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ser_load   = 1'b0;
        unique case (state)
            COLLECT: begin
                if (accept_in && (byte_cnt == 2'(BYTES_PER_WORD - 1))) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = EXEC;
            end
            EXEC: begin
                if (exec_cnt == 4'd1) begin
                    ser_load   = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (ser_done) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Byte counter wraps naturally to 0 on the fourth byte, ready for the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            assembly <= NOP_WORD;
            exec_cnt <= 4'd0;
            count_q  <= '0;
        end else begin
            if (accept_in) begin
                assembly[{byte_cnt, 3'b000} +: 8] <= in_byte;
                byte_cnt                          <= byte_cnt + 2'd1;
            end
            if (state == ISSUE) begin
                exec_cnt <= 4'(EXEC_CYCLES);
                count_q  <= count_q + CNT_WIDTH'(1);
            end else if (state == EXEC) begin
                exec_cnt <= exec_cnt - 4'd1;
            end
        end
    end

    byte_serializer u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (result_data),
        .out_byte  (out_byte),
        .out_valid (ser_valid),
        .out_ready (out_ready),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vectors, reset corner cases
// and randomized transactions scored against a word-level reference model.
module tb_instr_sequencer;

    localparam int EXEC_C = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             instr_valid;
    logic [31:0]      result_data;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int model_count = 0;

    logic [31:0] issued_q[$];
    logic [7:0]  drained_q[$];
    logic        prev_iv = 1'b0;
    logic        prev_ov = 1'b0;
    logic        prev_ordy = 1'b0;
    logic [7:0]  prev_byte = 8'h00;

    typedef struct packed {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] result;
        logic        gaps;
        logic        junk;
        logic [7:0]  stall;
        logic [31:0] exp_word;
        logic [7:0]  o0, o1, o2, o3;
    } vec_t;

    instr_sequencer #(.EXEC_CYCLES(EXEC_C), .CNT_WIDTH(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .result_data (result_data),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Passive scoreboard taps, sampled mid-cycle.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            issued_q.push_back(instr);
            checkOutput("strobe_width", {31'd0, prev_iv}, 32'd0);
        end else begin
            checkOutput("instr_nop", instr, 32'h0);
        end
        if (out_valid === 1'b1 && prev_ov && !prev_ordy) begin
            checkOutput("out_stable", {24'd0, out_byte}, {24'd0, prev_byte});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            drained_q.push_back(out_byte);
            checkOutput("in_ready_drain", {31'd0, in_ready}, 32'd0);
        end
        prev_iv   = (instr_valid === 1'b1);
        prev_ov   = (out_valid === 1'b1);
        prev_ordy = (out_ready === 1'b1);
        prev_byte = out_byte;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_count", 32'(instr_count), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_count = 0;
        tick();
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Leaves the bench in the cycle after the last byte was accepted.
    task automatic sendBytes(input logic [7:0] b [4], input int n, input logic gaps);
        int wait_n;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                repeat ($urandom_range(1, 2)) tick();
            end
            in_valid = 1'b1;
            in_byte  = b[k];
            wait_n   = 0;
            while (!in_ready && wait_n < 50) begin
                tick();
                wait_n++;
            end
            if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic applyStimulus(input logic [7:0] b [4], input logic [31:0] result,
                                 input logic [31:0] exp_word, input logic [7:0] exp_out [4],
                                 input logic gaps, input logic junk, input int stall,
                                 input logic rand_ready);
        int n;
        issued_q.delete();
        drained_q.delete();
        out_ready   = 1'b0;
        result_data = ~result;
        sendBytes(b, 4, gaps);
        // Issue cycle
        checkOutput("issue_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("issue_instr", instr, exp_word);
        checkOutput("issue_in_ready", {31'd0, in_ready}, 32'd0);
        if (junk) begin
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
        end
        // Result is only valid on the final execution cycle, so a mistimed capture is visible.
        for (int i = 1; i <= EXEC_C; i++) begin
            tick();
            result_data = (i == EXEC_C) ? result : ~result;
            checkOutput("exec_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("exec_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("exec_busy", {31'd0, busy}, 32'd1);
            if (junk) in_byte = 8'($urandom);
        end
        tick();
        result_data = ~result;
        in_valid    = 1'b0;
        checkOutput("drain_start", {31'd0, out_valid}, 32'd1);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            checkOutput("stall_byte", {24'd0, out_byte}, {24'd0, exp_out[0]});
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        n = 0;
        while (drained_q.size() < 4 && n < 200) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b0;
        checkOutput("drain_count", 32'(drained_q.size()), 32'd4);
        checkOutput("back_to_collect", {31'd0, in_ready}, 32'd1);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4 && k < drained_q.size(); k++) begin
            checkOutput($sformatf("out_byte%0d", k), {24'd0, drained_q[k]}, {24'd0, exp_out[k]});
        end
        checkOutput("issued_count", 32'(issued_q.size()), 32'd1);
        if (issued_q.size() > 0) checkOutput("issued_word", issued_q[0], exp_word);
        model_count = (model_count + 1) % (1 << CNT_W);
        checkOutput("instr_count", 32'(instr_count), 32'(model_count));
    endtask

    task automatic runVector(input vec_t v, input logic rand_ready);
        logic [7:0] b [4];
        logic [7:0] o [4];
        b[0] = v.b0; b[1] = v.b1; b[2] = v.b2; b[3] = v.b3;
        o[0] = v.o0; o[1] = v.o1; o[2] = v.o2; o[3] = v.o3;
        applyStimulus(b, v.result, v.exp_word, o, v.gaps, v.junk, int'(v.stall), rand_ready);
    endtask

    // Reference model: word and output bytes from plain little-endian arithmetic.
    task automatic runRandom(input logic allow_stall);
        logic [7:0]  b [4];
        logic [7:0]  o [4];
        logic [31:0] result;
        longint      word;
        word   = 0;
        result = $urandom;
        for (int k = 0; k < 4; k++) begin
            b[k] = 8'($urandom);
            word = word + longint'(b[k]) * (longint'(1) << (8 * k));
            o[k] = 8'((longint'(result) / (longint'(1) << (8 * k))) % 256);
        end
        applyStimulus(b, result, 32'(word), o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      allow_stall ? $urandom_range(0, 4) : 0, allow_stall);
    endtask

    vec_t vecs [4];

    initial begin
        logic [7:0] part [4];
        reset       = 1'b1;
        in_byte     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        result_data = 32'h0;

        vecs[0] = '{b0:8'hB3, b1:8'h00, b2:8'h31, b3:8'h00, result:32'hDEADBEEF, gaps:1'b0, junk:1'b0,
                    stall:8'd0,  exp_word:32'h003100B3, o0:8'hEF, o1:8'hBE, o2:8'hAD, o3:8'hDE};
        vecs[1] = '{b0:8'h13, b1:8'h05, b2:8'h50, b3:8'h00, result:32'h12345678, gaps:1'b0, junk:1'b0,
                    stall:8'd10, exp_word:32'h00500513, o0:8'h78, o1:8'h56, o2:8'h34, o3:8'h12};
        vecs[2] = '{b0:8'hFF, b1:8'hFF, b2:8'hFF, b3:8'hFF, result:32'h00000000, gaps:1'b1, junk:1'b1,
                    stall:8'd0,  exp_word:32'hFFFFFFFF, o0:8'h00, o1:8'h00, o2:8'h00, o3:8'h00};
        vecs[3] = '{b0:8'h03, b1:8'hA5, b2:8'h04, b3:8'h00, result:32'h80000001, gaps:1'b1, junk:1'b1,
                    stall:8'd3,  exp_word:32'h0004A503, o0:8'h01, o1:8'h00, o2:8'h00, o3:8'h80};

        doReset();
        for (int i = 0; i < 4; i++) runVector(vecs[i], 1'b0);

        // Partial word discarded by reset, then a fresh word.
        part[0] = 8'hAA; part[1] = 8'h55; part[2] = 8'h00; part[3] = 8'h00;
        sendBytes(part, 2, 1'b0);
        doReset();
        runVector(vecs[1], 1'b0);

        // Reset landing on the issue cycle must suppress the strobe.
        issued_q.delete();
        sendBytes(part, 4, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("rst_issue_no_strobe", 32'(issued_q.size()), 32'd0);
        checkOutput("rst_issue_count", 32'(instr_count), 32'd0);
        checkOutput("rst_issue_idle", {31'd0, out_valid}, 32'd0);
        model_count = 0;

        // Reset while a result is pending in drain; the next transaction must see only its own bytes.
        result_data = 32'hCAFEF00D;
        sendBytes(part, 4, 1'b0);
        out_ready = 1'b0;
        repeat (EXEC_C + 3) tick();
        checkOutput("pend_out_valid", {31'd0, out_valid}, 32'd1);
        doReset();
        runVector(vecs[0], 1'b1);

        for (int i = 0; i < 20; i++) runRandom(1'b1);

        // Counter wrap: 2^CNT_W + 1 issues from reset leaves a count of 1.
        doReset();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) runRandom(1'b0);
        checkOutput("count_wrap", 32'(instr_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
